dma_wr_engine: RTL and testbench
================================

Name: dma_wr_engine

Overview:
- Write half of the DMA; the downstream partner of the AR-channel read-command generator.
- Takes R-channel beats returned by the read side, buffers them in a small FIFO, and splits the transfer into 256-beat AW bursts (the last burst carries the remainder).
- Streams the buffered data out on the W channel with correct WLAST, and collects B responses.
- Signals completion to the control registers.

Parameters:
C_AXI_DATA_WIDTH, 32, AXI data and address width in bits.
FIFO_DEPTH, 16, R-to-W buffer depth in beats; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock. One clock domain; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  launch pulse. Ignored while busy=1.
- dst_addr  in  C_AXI_DATA_WIDTH  destination byte address. Sampled on start.
- size  in  16  beat count minus 1 (real_size-1). Sampled on start.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky: some BRESP was SLVERR or DECERR. Cleared on start.
- M_AXI_RDATA  in  C_AXI_DATA_WIDTH  read data from the read side.
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1
- M_AXI_AWADDR  out  C_AXI_DATA_WIDTH
- M_AXI_AWLEN  out  8
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  C_AXI_DATA_WIDTH
- M_AXI_WSTRB  out  C_AXI_DATA_WIDTH/8
- M_AXI_WLAST  out  1
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1

Behaviour:
- Reset: every output is 0 (busy, done, err, RREADY, AWADDR, AWLEN, AWVALID, WVALID, WLAST, BREADY). FIFO empty, all counters 0.
- Top FSM, IDLE:
  - On start: latch dst_addr into awaddr and size into size_r, set nbursts = size[15:8]+1 (9 bits, range 1..256), clear err, and go to RUN.
  - busy=1 from the next cycle.
- Top FSM, RUN → IDLE: on the cycle after the B handshake whose b_cnt reaches nbursts. done=1 for exactly that cycle; busy falls the same cycle.
- Reset mid-transfer: everything returns to reset values immediately. No done pulse.
- Burst k (0-based) length: AWLEN = (k == size_r[15:8]) ? size_r[7:0] : 8'hFF. The W side uses the same rule for its own burst index.
- AW issue:
  - AWVALID rises the cycle after RUN entry and stays high, with AWADDR and AWLEN stable, until AWREADY.
  - After each handshake: aw_cnt++, awaddr += (C_AXI_DATA_WIDTH/8)*256.
  - If aw_cnt < nbursts, AWVALID stays high with the new address in the next cycle (back-to-back bursts allowed). Otherwise AWVALID falls.
  - The 4KB-boundary and alignment rules are the caller's responsibility and are not checked.
- R intake: RREADY = busy && !fifo_full. On RVALID&&RREADY, RDATA is pushed.
- W output:
  - W burst k may start only when aw_cnt > k; W never leads its AW.
  - WVALID = RUN && !fifo_empty && (w_burst < aw_cnt) && (w_burst < nbursts).
  - WDATA = FIFO head, shown combinationally. WSTRB is all ones.
  - beat_cnt counts beats within the burst. WLAST = WVALID && (beat_cnt == current burst length).
  - On WVALID&&WREADY: pop the FIFO. If WLAST, set beat_cnt=0 and w_burst++; else beat_cnt++.
  - WVALID and WDATA hold until WREADY.
- B: BREADY = busy. On BVALID&&BREADY: b_cnt++. If BRESP[1]=1, err is set and stays set until the next start.
- FIFO:
  - Push and pop in the same cycle are legal (count unchanged).
  - Push is impossible while full; pop is impossible while empty.
  - Read-to-write latency through the FIFO is at least 1 cycle: a beat pushed in cycle n may appear on W in cycle n+1.
- Counter widths: aw_cnt, w_burst and b_cnt are 9 bits; beat_cnt is 8 bits; FIFO pointers are log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package dma_pkg holds:
  - BURST_BEATS = 256;
  - AXI_RESP_OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the burst-length function (index, size) → AWLEN, shared with the read-command generator.
- One sub-module: dma_sync_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty). It is first-word-fall-through.

Test Plan:
- size=0, dst=0x1000, all readies high, one R beat 0xA5A5A5A5 → one AW (0x1000, LEN 0); one W beat 0xA5A5A5A5 with WLAST=1; done one cycle after BVALID.
- size=0x0100, dst=0x2000 → AW1 (0x2000, LEN 0xFF) then AW2 (0x2400, LEN 0x00); WLAST on beats 256 and 257 only; done after the 2nd B.
- size=0xFFFF → 256 AWs, all LEN 0xFF, last AWADDR = dst+0x3FC00; 65536 W beats; done after 256 B responses.
- Same as the previous case but with WREADY held low for 40 cycles → FIFO fills to 16, RREADY falls, no beat is lost or duplicated, and W data order matches R order.
- AWREADY delayed 10 cycles → WVALID stays 0 until the AW handshake; afterwards AWADDR and AWLEN stay stable while AWVALID waits.
- 2nd B returns BRESP=2'b10 → err=1 and done still pulses. A new start clears err. Asserting rst_n=0 mid-burst gives all outputs 0 with no done pulse.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA read/write engines.
package dma_pkg;

  localparam int BURST_BEATS = 256;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } dma_state_e;

  // Length field of burst idx for a transfer of size+1 beats: every burst is
  // full except the final one, which carries the remainder.
  function automatic logic [7:0] burst_len(input logic [8:0] idx, input logic [15:0] size);
    return (idx == {1'b0, size[15:8]}) ? size[7:0] : 8'hFF;
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head is visible on dout
// whenever empty is low. Pushes while full and pops while empty are dropped.
module dma_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  // NOTE: the data array has no reset; the pointers alone define which entries
  // are valid, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dma_wr_engine.sv
// DMA write engine: buffers R beats, issues 256-beat AW bursts, streams W with
// WLAST, counts B responses and pulses done when the last response returns.
module dma_wr_engine
  import dma_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [C_AXI_DATA_WIDTH-1:0]   dst_addr,
  input  logic [15:0]                   size,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY
);

  localparam logic [C_AXI_DATA_WIDTH-1:0] BURST_BYTES =
    C_AXI_DATA_WIDTH'((C_AXI_DATA_WIDTH / 8) * BURST_BEATS);

  dma_state_e                  state_q, state_d;
  logic [C_AXI_DATA_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [15:0]                 size_q, size_d;
  logic [8:0]                  nbursts_q, nbursts_d;
  logic [8:0]                  aw_cnt_q, aw_cnt_d;
  logic [8:0]                  w_burst_q, w_burst_d;
  logic [8:0]                  b_cnt_q, b_cnt_d;
  logic [7:0]                  beat_cnt_q, beat_cnt_d;
  logic                        err_q, err_d;
  logic                        done_q, done_d;

  logic run, aw_hs, w_hs, b_hs, w_last;
  logic fifo_full, fifo_empty;
  logic [C_AXI_DATA_WIDTH-1:0] fifo_dout;

  assign run           = (state_q == ST_RUN);
  assign busy          = run;
  assign done          = done_q;
  assign err           = err_q;

  assign M_AXI_RREADY  = run && !fifo_full;

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = run && (aw_cnt_q < nbursts_q);
  assign M_AXI_AWLEN   = run ? burst_len(aw_cnt_q, size_q) : 8'h00;
  assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;

  // A W burst may only start once its own AW has been accepted.
  assign M_AXI_WVALID  = run && !fifo_empty && (w_burst_q < aw_cnt_q) && (w_burst_q < nbursts_q);
  assign w_last        = M_AXI_WVALID && (beat_cnt_q == burst_len(w_burst_q, size_q));
  assign M_AXI_WLAST   = w_last;
  assign M_AXI_WDATA   = fifo_dout;
  assign M_AXI_WSTRB   = '1;
  assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;

  assign M_AXI_BREADY  = run;
  assign b_hs          = M_AXI_BVALID && run;

  dma_sync_fifo #(
    .WIDTH (C_AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (M_AXI_RVALID && M_AXI_RREADY),
    .pop   (w_hs),
    .din   (M_AXI_RDATA),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic for the transfer FSM and its counters.
  // NOTE: every _d gets its hold value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    size_d     = size_q;
    nbursts_d  = nbursts_q;
    aw_cnt_d   = aw_cnt_q;
    w_burst_d  = w_burst_q;
    b_cnt_d    = b_cnt_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          awaddr_d   = dst_addr;
          size_d     = size;
          nbursts_d  = {1'b0, size[15:8]} + 9'd1;
          aw_cnt_d   = '0;
          w_burst_d  = '0;
          b_cnt_d    = '0;
          beat_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      ST_RUN: begin
        if (aw_hs) begin
          aw_cnt_d = aw_cnt_q + 9'd1;
          awaddr_d = awaddr_q + BURST_BYTES;
        end
        if (w_hs) begin
          if (w_last) begin
            beat_cnt_d = '0;
            w_burst_d  = w_burst_q + 9'd1;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
        if (b_hs) begin
          b_cnt_d = b_cnt_q + 9'd1;
          if (M_AXI_BRESP == AXI_RESP_SLVERR || M_AXI_BRESP == AXI_RESP_DECERR) err_d = 1'b1;
          if (b_cnt_q + 9'd1 == nbursts_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  // NOTE: sequential state uses non-blocking assignment so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      awaddr_q   <= '0;
      size_q     <= '0;
      nbursts_q  <= '0;
      aw_cnt_q   <= '0;
      w_burst_q  <= '0;
      b_cnt_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      size_q     <= size_d;
      nbursts_q  <= nbursts_d;
      aw_cnt_q   <= aw_cnt_d;
      w_burst_q  <= w_burst_d;
      b_cnt_q    <= b_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_dma_wr_engine.sv
// Bench for dma_wr_engine: an R source, AW/W/B responders and scoreboard
// queues of expected AW commands and W beats.
module tb_dma_wr_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dst_addr;
  logic [15:0] size;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  dma_wr_engine #(.C_AXI_DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dst_addr      (dst_addr),
    .size          (size),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWLEN   (awlen),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WLAST   (wlast),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_exp_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_pattern(input int idx, input logic [31:0] seed);
    return (32'(idx) * 32'h9E37_79B9) ^ seed;
  endfunction

  task automatic idle_inputs();
    start    = 1'b0;
    dst_addr = '0;
    size     = '0;
    rdata    = '0;
    rvalid   = 1'b0;
    awready  = 1'b0;
    wready   = 1'b0;
    bresp    = 2'b00;
    bvalid   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {busy, done, err, rready, awaddr, awlen, awvalid, wvalid, wlast, bready}, '0);
  endtask

  // One transfer. aw_delay: cycles AWREADY stays low; stall_*: WREADY low
  // window; err_burst: 1-based B response returned as SLVERR (0 = none);
  // abort_at: cycle at which reset is pulsed (0 = never).
  task automatic run_xfer(input logic [31:0] addr, input logic [15:0] sz, input int aw_delay,
                          input int stall_at, input int stall_len, input int err_burst,
                          input logic [31:0] seed, input int abort_at);
    int nb, total, budget, r_idx, aw_hs, w_bursts, b_pend, b_hs, occ, max_occ;
    logic expect_done, finished, aborted;
    logic prev_awv, prev_awr, prev_wv, prev_wr;
    logic [31:0] prev_addr, prev_wdata;
    logic [7:0]  prev_len;
    aw_exp_t ae;
    w_exp_t  we;

    nb     = int'(sz[15:8]) + 1;
    total  = int'(sz) + 1;
    budget = total + aw_delay + stall_len + 600;
    aw_q.delete();
    w_q.delete();
    for (int k = 0; k < nb; k++) begin
      ae.addr = addr + 32'(k) * 32'h400;
      ae.len  = (k == nb - 1) ? sz[7:0] : 8'hFF;
      aw_q.push_back(ae);
    end
    r_idx = 0; aw_hs = 0; w_bursts = 0; b_pend = 0; b_hs = 0; occ = 0; max_occ = 0;
    expect_done = 1'b0; finished = 1'b0; aborted = 1'b0;
    prev_awv = 1'b0; prev_awr = 1'b0; prev_wv = 1'b0; prev_wr = 1'b0;
    prev_addr = '0; prev_wdata = '0; prev_len = '0;

    @(negedge clk);
    dst_addr = addr;
    size     = sz;
    start    = 1'b1;

    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      @(negedge clk);
      start   = 1'b0;
      rvalid  = (r_idx < total);
      rdata   = r_pattern(r_idx, seed);
      awready = (cyc >= aw_delay);
      wready  = !(cyc >= stall_at && cyc < stall_at + stall_len);
      bvalid  = (b_pend > 0);
      bresp   = (b_hs + 1 == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (abort_at != 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_outputs");
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("abort_no_done", {done, busy}, 2'b00);
        end
        idle_inputs();
        rst_n = 1'b1;
        finished = 1'b1;
        aborted  = 1'b1;
      end else if (expect_done) begin
        check("done", done, 1'b1);
        check("busy_after_done", busy, 1'b0);
        finished = 1'b1;
      end else begin
        if (cyc == 0) check("err_cleared", err, 1'b0);
        check("done_early", done, 1'b0);
        check("busy", {busy, bready}, 2'b11);
        check("rready", rready, occ < 16);
        if (prev_awv && !prev_awr)
          check("aw_stable", {awvalid, awaddr, awlen}, {1'b1, prev_addr, prev_len});
        if (prev_wv && !prev_wr)
          check("w_hold", {wvalid, wdata}, {1'b1, prev_wdata});
        if (aw_hs == 0) check("wvalid_pre_aw", wvalid, 1'b0);
        if (wvalid) check("w_after_aw", w_bursts < aw_hs, 1'b1);
        if (awvalid && awready) begin
          if (aw_q.size() == 0) check("aw_extra", 1'b1, 1'b0);
          else begin
            ae = aw_q.pop_front();
            check("aw", {awaddr, awlen}, {ae.addr, ae.len});
          end
          aw_hs++;
        end
        if (wvalid && wready) begin
          if (w_q.size() == 0) check("w_extra", 1'b1, 1'b0);
          else begin
            we = w_q.pop_front();
            check("w_beat", {wdata, wlast}, {we.data, we.last});
          end
          check("wstrb", wstrb, 4'hF);
          occ--;
          if (wlast) begin
            w_bursts++;
            b_pend++;
          end
        end
        if (rvalid && rready) begin
          we.data = rdata;
          we.last = (r_idx % 256 == 255) || (r_idx == total - 1);
          w_q.push_back(we);
          r_idx++;
          occ++;
          if (occ > max_occ) max_occ = occ;
        end
        if (bvalid && bready) begin
          b_pend--;
          b_hs++;
          if (b_hs == nb) expect_done = 1'b1;
        end
        prev_awv = awvalid; prev_awr = awready; prev_addr = awaddr; prev_len = awlen;
        prev_wv  = wvalid;  prev_wr  = wready;  prev_wdata = wdata;
      end
    end

    if (!finished) check("timeout", 1'b0, 1'b1);
    if (!aborted) begin
      check("aw_left", 64'(aw_q.size()), 0);
      check("w_left", 64'(w_q.size()), 0);
      check("b_count", 64'(b_hs), 64'(nb));
      check("err_final", err, (err_burst >= 1 && err_burst <= nb));
      if (stall_len > 0) check("fifo_filled", 64'(max_occ), 16);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_outputs");

    // single beat
    run_xfer(32'h0000_1000, 16'h0000, 0, 0, 0, 0, 32'hA5A5_A5A5, 0);
    // full burst plus one-beat remainder
    run_xfer(32'h0000_2000, 16'h0100, 0, 0, 0, 0, 32'h1234_5678, 0);
    // AWREADY held off for 10 cycles
    run_xfer(32'h0000_8000, 16'h001F, 10, 0, 0, 0, 32'h0BAD_F00D, 0);
    // 3 bursts, 2nd response SLVERR
    run_xfer(32'h0001_0000, 16'h02FF, 0, 0, 0, 2, 32'hCAFE_0001, 0);
    // next start clears err
    run_xfer(32'h0002_0000, 16'h0005, 0, 0, 0, 0, 32'hCAFE_0002, 0);
    // maximum transfer with a 40-cycle WREADY stall
    run_xfer(32'h0010_0000, 16'hFFFF, 0, 1000, 40, 0, 32'h5A5A_0F0F, 0);
    // reset mid-transfer, then recovery
    run_xfer(32'h0003_0000, 16'h01FF, 0, 0, 0, 0, 32'h7777_0000, 100);
    check_all_zero("post_abort");
    run_xfer(32'h0004_0000, 16'h0003, 0, 0, 0, 0, 32'h3C3C_3C3C, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
